// File: rtl/aurora_stream_bridge.sv
// User <-> Aurora lane bridge: FWFT TX/RX FIFOs (1-cycle push-to-head), traffic gated to link UP; TX backpressured, RX drops on full.
// Optional error counters when AURORA_ERR_CNT_EN is defined; otherwise the counter ports are tied to zero.
module aurora_stream_bridge #(
    parameter int DATA_W       = 16,
    parameter int FIFO_DEPTH   = 16,
    parameter int DEBOUNCE_LEN = 4
) (
    input  logic              USER_CLK,
    input  logic              RESET_N,
    input  logic              RESET_BTN,
    input  logic [DATA_W-1:0] TX_D,
    input  logic              TX_SRC_RDY,
    output logic              TX_DST_RDY,
    output logic [DATA_W-1:0] RX_D,
    output logic              RX_SRC_RDY,
    input  logic              RX_DST_RDY,
    output logic [DATA_W-1:0] CORE_TX_D,
    output logic              CORE_TX_SRC_RDY_N,
    input  logic              CORE_TX_DST_RDY_N,
    input  logic [DATA_W-1:0] CORE_RX_D,
    input  logic              CORE_RX_SRC_RDY_N,
    input  logic              CORE_HARD_ERROR,
    input  logic              CORE_SOFT_ERROR,
    input  logic              CORE_LANE_UP,
    input  logic              CORE_CHANNEL_UP,
    output logic              CORE_RESET,
    output logic              HARD_ERROR,
    output logic              SOFT_ERROR,
    output logic              LANE_UP,
    output logic              CHANNEL_UP,
    output logic [1:0]        LINK_STATE,
    output logic              RX_OVERFLOW,
    output logic [15:0]       SOFT_ERR_CNT,
    output logic [15:0]       HARD_ERR_CNT
);
    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [1:0] ST_RESET   = 2'b00;
    localparam logic [1:0] ST_WAIT_UP = 2'b01;
    localparam logic [1:0] ST_UP      = 2'b10;
    localparam logic [1:0] ST_FLUSH   = 2'b11;

    logic [DEBOUNCE_LEN-1:0] db_q, db_d;
    logic                    rst_db;
    logic                    hard_q, soft_q, lane_q, chan_q;
    logic [1:0]              state_q, state_d;
    logic                    link_up, flush;
    logic                    rx_ovf_q, rx_ovf_d;

    logic [DATA_W-1:0] tx_mem_q [FIFO_DEPTH];
    logic [DATA_W-1:0] rx_mem_q [FIFO_DEPTH];
    logic [AW:0]       tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
    logic [AW:0]       rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
    logic              tx_empty, tx_full, tx_push, tx_pop;
    logic              rx_empty, rx_full, rx_req, rx_push, rx_pop, rx_drop;

    assign db_d    = {db_q[DEBOUNCE_LEN-2:0], RESET_BTN};
    assign rst_db  = &db_q;
    assign link_up = (state_q == ST_UP);
    assign flush   = (state_q == ST_FLUSH);

    always_comb begin
        state_d = state_q;
        if (rst_db) begin
            state_d = ST_RESET;
        end else begin
            case (state_q)
                ST_RESET:   state_d = ST_WAIT_UP;
                ST_WAIT_UP: if (chan_q) state_d = ST_UP;
                ST_UP:      if (!chan_q || hard_q) state_d = ST_FLUSH;
                default:    state_d = ST_WAIT_UP;
            endcase
        end
    end

    always_ff @(posedge USER_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            db_q    <= '1;
            hard_q  <= 1'b0;
            soft_q  <= 1'b0;
            lane_q  <= 1'b0;
            chan_q  <= 1'b0;
            state_q <= ST_RESET;
        end else begin
            db_q    <= db_d;
            hard_q  <= CORE_HARD_ERROR;
            soft_q  <= CORE_SOFT_ERROR;
            lane_q  <= CORE_LANE_UP;
            chan_q  <= CORE_CHANNEL_UP;
            state_q <= state_d;
        end
    end

    // Full: pointers share the index bits but differ in the wrap bit.
    assign tx_empty = (tx_wr_q == tx_rd_q);
    assign tx_full  = (tx_wr_q[AW] != tx_rd_q[AW]) && (tx_wr_q[AW-1:0] == tx_rd_q[AW-1:0]);
    assign rx_empty = (rx_wr_q == rx_rd_q);
    assign rx_full  = (rx_wr_q[AW] != rx_rd_q[AW]) && (rx_wr_q[AW-1:0] == rx_rd_q[AW-1:0]);

    assign TX_DST_RDY        = !tx_full && link_up;
    assign CORE_TX_SRC_RDY_N = !(!tx_empty && link_up);
    assign CORE_TX_D         = tx_mem_q[tx_rd_q[AW-1:0]];
    assign tx_push           = TX_SRC_RDY && TX_DST_RDY;
    assign tx_pop            = !CORE_TX_SRC_RDY_N && !CORE_TX_DST_RDY_N;

    // The core cannot be stalled: a word meeting a full FIFO is only kept if the head leaves this cycle.
    assign RX_SRC_RDY = !rx_empty;
    assign RX_D       = rx_mem_q[rx_rd_q[AW-1:0]];
    assign rx_req     = !CORE_RX_SRC_RDY_N && link_up;
    assign rx_pop     = !rx_empty && RX_DST_RDY;
    assign rx_push    = rx_req && (!rx_full || rx_pop);
    assign rx_drop    = rx_req && rx_full && !rx_pop;

    always_comb begin
        tx_wr_d  = tx_wr_q;
        tx_rd_d  = tx_rd_q;
        rx_wr_d  = rx_wr_q;
        rx_rd_d  = rx_rd_q;
        rx_ovf_d = rx_ovf_q;
        if (flush || state_q == ST_RESET) begin
            rx_ovf_d = 1'b0;
        end else if (rx_drop) begin
            rx_ovf_d = 1'b1;
        end
        if (flush) begin
            tx_wr_d = '0;
            tx_rd_d = '0;
            rx_wr_d = '0;
            rx_rd_d = '0;
        end else begin
            if (tx_push) tx_wr_d = tx_wr_q + 1'b1;
            if (tx_pop)  tx_rd_d = tx_rd_q + 1'b1;
            if (rx_push) rx_wr_d = rx_wr_q + 1'b1;
            if (rx_pop)  rx_rd_d = rx_rd_q + 1'b1;
        end
    end

    always_ff @(posedge USER_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            tx_wr_q  <= '0;
            tx_rd_q  <= '0;
            rx_wr_q  <= '0;
            rx_rd_q  <= '0;
            rx_ovf_q <= 1'b0;
        end else begin
            tx_wr_q  <= tx_wr_d;
            tx_rd_q  <= tx_rd_d;
            rx_wr_q  <= rx_wr_d;
            rx_rd_q  <= rx_rd_d;
            rx_ovf_q <= rx_ovf_d;
        end
    end

    always_ff @(posedge USER_CLK) begin
        if (tx_push) tx_mem_q[tx_wr_q[AW-1:0]] <= TX_D;
        if (rx_push) rx_mem_q[rx_wr_q[AW-1:0]] <= CORE_RX_D;
    end

`ifdef AURORA_ERR_CNT_EN
    logic [15:0] soft_cnt_q, soft_cnt_d, hard_cnt_q, hard_cnt_d;

    always_comb begin
        soft_cnt_d = soft_cnt_q;
        hard_cnt_d = hard_cnt_q;
        if (state_q == ST_RESET) begin
            soft_cnt_d = '0;
            hard_cnt_d = '0;
        end else begin
            if (soft_q && soft_cnt_q != 16'hFFFF) soft_cnt_d = soft_cnt_q + 16'd1;
            if (hard_q && hard_cnt_q != 16'hFFFF) hard_cnt_d = hard_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge USER_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            soft_cnt_q <= '0;
            hard_cnt_q <= '0;
        end else begin
            soft_cnt_q <= soft_cnt_d;
            hard_cnt_q <= hard_cnt_d;
        end
    end

    assign SOFT_ERR_CNT = soft_cnt_q;
    assign HARD_ERR_CNT = hard_cnt_q;
`else
    assign SOFT_ERR_CNT = 16'h0000;
    assign HARD_ERR_CNT = 16'h0000;
`endif

    assign CORE_RESET  = rst_db || (state_q == ST_RESET);
    assign HARD_ERROR  = hard_q;
    assign SOFT_ERROR  = soft_q;
    assign LANE_UP     = lane_q;
    assign CHANNEL_UP  = chan_q;
    assign LINK_STATE  = state_q;
    assign RX_OVERFLOW = rx_ovf_q;

endmodule
